// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus bridge.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      DONE    = 2'd2,
      RELEASE = 2'd3
   } state_e;

   localparam int TIMEOUT_DEF = 16;

   // Wide enough for any supported DATA_W; users slice the low DATA_W bits.
   localparam int                    ERR_W_MAX = 64;
   localparam logic [ERR_W_MAX-1:0]  ERR_RDATA = '1;

endpackage

// File: rtl/mem_bus_bridge_timeout_counter.sv
// Saturating cycle counter; expired fires in the cycle whose count step reaches LIMIT.
module timeout_counter #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int           W   = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] cnt;
   logic [W-1:0] cnt_inc;

   // Stop at LIM so a long stall can never wrap back below the limit.
   assign cnt_inc = (cnt == LIM) ? cnt : cnt + 1'b1;
   assign expired = enable && (cnt_inc == LIM);

   // Count enabled cycles; clear restarts the window for a new access.
   always_ff @(posedge clk) begin
      if (!rst || clear) cnt <= '0;
      else if (enable)   cnt <= cnt_inc;
   end

endmodule

// File: rtl/mem_bus_bridge.sv
// Bridges level-sensitive mem_read/mem_write from a multi-cycle CPU controller
// onto a single-ack external bus, with alignment checking and an access timeout.
module mem_bus_bridge
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_done,
   output logic              bus_err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata
);

   state_e            state, state_nxt;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              lat_we;
   logic              err_flag;
   logic              req_any, req_ok, req_bad;
   logic              in_access;
   logic              cnt_clr, cnt_en, expired;

   // A legal request is exactly one direction and word aligned.
   assign req_any   = mem_read | mem_write;
   assign req_ok    = (mem_read ^ mem_write) && (addr[1:0] == 2'b00);
   assign req_bad   = req_any && !req_ok;
   assign in_access = (state == ACCESS);

   assign cnt_clr = (state == IDLE) && req_ok;
   assign cnt_en  = in_access && !bus_ack;

   timeout_counter #(.LIMIT(TIMEOUT)) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clear   (cnt_clr),
      .enable  (cnt_en),
      .expired (expired)
   );

   // Next-state decode; ack wins over a coincident timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_ok)       state_nxt = ACCESS;
            else if (req_bad) state_nxt = DONE;
         end
         ACCESS:  if (bus_ack || expired) state_nxt = DONE;
         DONE:    state_nxt = RELEASE;
         RELEASE: if (!req_any) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Request latch, error flag and read-data capture.
   always_ff @(posedge clk) begin
      if (!rst) begin
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_we    <= 1'b0;
         err_flag  <= 1'b0;
         rdata     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_ok) begin
                  lat_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  lat_wdata <= wdata;
                  lat_we    <= mem_write;
                  err_flag  <= 1'b0;
               end else if (req_bad) begin
                  err_flag  <= 1'b1;
               end
            end
            ACCESS: begin
               if (bus_ack) begin
                  if (!lat_we) rdata <= bus_rdata;
                  err_flag <= 1'b0;
               end else if (expired) begin
                  if (!lat_we) rdata <= ERR_RDATA[DATA_W-1:0];
                  err_flag <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Bus side is only driven while an access is in flight, zero otherwise.
   assign bus_req   = in_access;
   assign bus_we    = in_access & lat_we;
   assign bus_addr  = in_access ? lat_addr  : '0;
   assign bus_wdata = in_access ? lat_wdata : '0;
   assign mem_done  = (state == DONE);
   assign bus_err   = mem_done & err_flag;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Scoreboard bench for mem_bus_bridge: stimulus queues expected completions,
// a negedge monitor checks each mem_done against the queue.
module tb_mem_bus_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_read = 1'b0, mem_write = 1'b0, bus_ack = 1'b0;
   logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
   logic [31:0] rdata, bus_addr, bus_wdata;
   logic        mem_done, bus_err, bus_req, bus_we;

   int errors = 0;
   int checks = 0;
   logic [32:0] sb_q[$];

   always #5 clk = ~clk;

   mem_bus_bridge dut (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .mem_done  (mem_done),
      .bus_err   (bus_err),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Completion monitor: every mem_done must match the oldest queued expectation.
   always @(negedge clk) begin : mon
      logic [32:0] e;
      if (mem_done) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got err=%0b rdata=%0h expected no completion", bus_err, rdata);
         end else begin
            e = sb_q.pop_front();
            if ({bus_err, rdata} !== e) begin
               errors++;
               $display("FAIL done_resp: got err=%0b rdata=%0h expected err=%0b rdata=%0h",
                        bus_err, rdata, e[32], e[31:0]);
            end
         end
      end else if (bus_err) begin
         checks++;
         errors++;
         $display("FAIL stray_err: got bus_err=1 expected 0 without mem_done");
      end
   end

   // One transaction: ack_dly = ACCESS cycle on which to ack (0 = never),
   // exp_lat = negedges after the request edge until mem_done.
   task automatic run(input string nm, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int ack_dly, input logic [31:0] brd,
                      input logic exp_err, input logic [31:0] exp_rd,
                      input int exp_req, input int exp_lat, input int hold);
      int req_cyc;
      int cyc;
      bit done;
      logic [31:0] a_al;
      req_cyc = 0; cyc = 0; done = 0;
      a_al = {a[31:2], 2'b00};
      sb_q.push_back({exp_err, exp_rd});
      @(negedge clk);
      mem_read = rd; mem_write = wr; addr = a; wdata = wd;
      while (!done && cyc < 64) begin
         @(negedge clk);
         cyc++;
         bus_ack = 1'b0;
         if (mem_done) done = 1;
         else if (bus_req) begin
            req_cyc++;
            chk({nm, "_bus_addr"},  bus_addr,  a_al);
            chk({nm, "_bus_we"},    bus_we,    wr);
            chk({nm, "_bus_wdata"}, bus_wdata, wd);
            if (req_cyc == ack_dly) begin
               bus_ack = 1'b1;
               bus_rdata = brd;
            end
         end
      end
      if (!done) begin
         errors++; checks++;
         $display("FAIL %s_no_done: got no mem_done in 64 cycles expected one", nm);
      end
      chk({nm, "_req_cycles"}, req_cyc, exp_req);
      chk({nm, "_latency"},    cyc,     exp_lat);
      repeat (hold) begin
         @(negedge clk);
         chk({nm, "_hold_req"}, bus_req, 0);
      end
      mem_read = 1'b0; mem_write = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int guard;
      repeat (3) @(negedge clk);
      chk("rst_rdata",     rdata,     0);
      chk("rst_mem_done",  mem_done,  0);
      chk("rst_bus_err",   bus_err,   0);
      chk("rst_bus_req",   bus_req,   0);
      chk("rst_bus_we",    bus_we,    0);
      chk("rst_bus_addr",  bus_addr,  0);
      chk("rst_bus_wdata", bus_wdata, 0);
      rst = 1'b1;

      // Ack while idle must be ignored.
      @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
      @(negedge clk); bus_ack = 1'b0;
      chk("idle_ack_rdata",   rdata,   0);
      chk("idle_ack_bus_req", bus_req, 0);

      //  name       rd wr addr          wdata         ack brdata        err exp_rdata     req lat hold
      run("rd_ack3",  1, 0, 32'h0000_0010, 32'h0,         3,  32'h2008_0005, 0, 32'h2008_0005, 3,  4,  0);
      run("wr_imm",   0, 1, 32'h0000_0024, 32'hCAFE_F00D, 1,  32'hDEAD_BEEF, 0, 32'h2008_0005, 1,  2,  0);
      run("rd_mis",   1, 0, 32'h0000_0013, 32'h0,         0,  32'h0,         1, 32'h2008_0005, 0,  1,  0);
      run("rw_both",  1, 1, 32'h0000_0020, 32'h0,         0,  32'h0,         1, 32'h2008_0005, 0,  1,  0);
      run("rd_tmo",   1, 0, 32'h0000_0040, 32'h0,         0,  32'h0,         1, 32'hFFFF_FFFF, 16, 17, 0);
      run("wr_tmo",   0, 1, 32'h0000_0044, 32'h5555_AAAA, 0,  32'h0,         1, 32'hFFFF_FFFF, 16, 17, 0);
      run("rd_ack16", 1, 0, 32'h0000_0048, 32'h0,         16, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 16, 17, 0);
      run("rd_hold",  1, 0, 32'h0000_0050, 32'h0,         1,  32'h1111_2222, 0, 32'h1111_2222, 1,  2,  5);
      run("rd_after", 1, 0, 32'h0000_0054, 32'h0,         2,  32'h3333_4444, 0, 32'h3333_4444, 2,  3,  0);

      // Reset on the 2nd ACCESS cycle, then a late ack.
      @(negedge clk); mem_read = 1'b1; addr = 32'h0000_0060;
      n = 0; guard = 0;
      while (n < 2 && guard < 10) begin
         @(negedge clk);
         guard++;
         if (bus_req) n++;
      end
      if (n < 2) begin
         errors++; checks++;
         $display("FAIL rstacc_enter: got %0d access cycles expected 2", n);
      end
      rst = 1'b0; mem_read = 1'b0;
      @(negedge clk);
      chk("rstacc_bus_req",   bus_req,   0);
      chk("rstacc_mem_done",  mem_done,  0);
      chk("rstacc_rdata",     rdata,     0);
      chk("rstacc_bus_addr",  bus_addr,  0);
      chk("rstacc_bus_we",    bus_we,    0);
      chk("rstacc_bus_wdata", bus_wdata, 0);
      rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
      @(negedge clk); bus_ack = 1'b0;
      chk("late_ack_bus_req", bus_req, 0);
      chk("late_ack_rdata",   rdata,   0);
      repeat (4) @(negedge clk);

      chk("sb_empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_bus_bridge.md
MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32: word width.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles without bus_ack.
REQ-004 SHALL have these ports:
- clk  in  1  system clock; one clock domain, rising edge.
- rst  in  1  reset; synchronous and active-low.
- mem_read  in  1  read request, level, from the multi-cycle controller.
- mem_write  in  1  write request, level, from the multi-cycle controller.
- addr  in  ADDR_W  byte address (PC or ALU result, selected by IorD upstream).
- wdata  in  DATA_W  store data (register B).
- rdata  out  DATA_W  read word, registered, routed to IR / MDR.
- mem_done  out  1  one-cycle completion pulse (read, write or error).
- bus_err  out  1  one-cycle error pulse, coincident with mem_done.
- bus_req  out  1  external bus request.
- bus_we  out  1  external write enable.
- bus_addr  out  ADDR_W  word-aligned address.
- bus_wdata  out  DATA_W  external write data.
- bus_ack  in  1  external completion, single-cycle.
- bus_rdata  in  DATA_W  external read data, valid when bus_ack=1.

Function
REQ-005 SHALL implement FSM states IDLE, ACCESS, DONE, RELEASE.
REQ-006 IDLE, exactly one of mem_read or mem_write high, addr[1:0]=00: SHALL latch addr, wdata and we=mem_write, then go to ACCESS.
REQ-007 IDLE, request with addr[1:0]!=00, or mem_read and mem_write both high: SHALL start no bus cycle, SHALL flag an error, SHALL go to DONE.
REQ-008 ACCESS: SHALL drive bus_req=1, bus_we=latched we, bus_addr={addr[ADDR_W-1:2],2'b00}, bus_wdata=latched wdata, all held stable until exit.
REQ-009 ACCESS with bus_ack=1: SHALL load rdata<=bus_rdata on reads (rdata unchanged on writes), SHALL go to DONE.
REQ-010 Timeout: the counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack.
REQ-011 When the count reaches TIMEOUT, the block SHALL flag an error, load rdata<=all-ones on reads, and go to DONE; a bus_ack in that same cycle SHALL take priority (normal completion).
REQ-012 DONE: mem_done=1 and bus_err=error flag for exactly one cycle; SHALL go to RELEASE.
REQ-013 RELEASE: SHALL wait until mem_read=0 and mem_write=0, then go to IDLE; a held request SHALL NOT retrigger.
REQ-014 Latency: request sampled at edge N gives bus_req=1 after N; bus_ack sampled at edge M gives mem_done=1 after M; the minimum is 2 cycles from request to mem_done.
REQ-015 bus_ack outside ACCESS SHALL be ignored.
REQ-016 rdata SHALL hold its value until the next completed read.
REQ-017 The counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL saturate, never wrap.

Reset
REQ-018 rst=0 at a rising edge SHALL force IDLE and set rdata=0, mem_done=0, bus_err=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, counter=0 and error flag=0.
REQ-019 Reset during ACCESS SHALL drop bus_req after that edge with no mem_done; a late bus_ack SHALL be ignored.

Structure
REQ-020 Shared package mem_bus_pkg SHALL hold the state enum (2 bits), the TIMEOUT default and ERR_RDATA (all-ones).
REQ-021 The timeout counter SHALL be one sub-module, timeout_counter (clear, enable, saturate, expired output).

Verification
REQ-022 Read, addr=0x0000_0010, bus_ack 3 cycles after bus_req rises with bus_rdata=0x2008_0005 -> bus_addr=0x10; mem_done after the ack edge; rdata=0x2008_0005; bus_err=0.
REQ-023 Write, addr=0x0000_0024, wdata=0xCAFE_F00D, immediate ack -> bus_we=1, bus_wdata=0xCAFE_F00D; mem_done 2 cycles after the request; rdata unchanged.
REQ-024 Read, addr=0x0000_0013 -> bus_req stays 0; mem_done=1 and bus_err=1 on the same cycle.
REQ-025 Read with no ack, TIMEOUT=16 -> bus_req high exactly 16 cycles; then mem_done=1, bus_err=1, rdata=0xFFFF_FFFF.
REQ-026 mem_read held 5 cycles after mem_done -> exactly one bus cycle; a new request is accepted only after mem_read drops.
REQ-027 rst=0 on the 2nd ACCESS cycle, then ack -> bus_req=0 after reset; no mem_done; outputs at reset values.
